// File: rtl/strobe_chk_pkg.sv
// Shared types and defaults for the receive-side strobe cadence checker.
package strobe_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } chk_state_t;

    localparam int LOCK_CNT_DEF   = 4;
    localparam int UNLOCK_CNT_DEF = 3;
    localparam int POS_W          = 16;
    localparam int ERR_W          = 16;
    localparam int RUN_W          = 4;

    // Run-length counters stop at all-ones so they can never wrap back below a threshold.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
        run_inc = (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coincident with an increment leaves a count of one.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;

    // Next count: clear wins over hold, increment stops at the maximum.
    always_comb begin
        w_count_nxt = r_count;
        if (clr) begin
            w_count_nxt = inc ? CNT_ONE : CNT_ZERO;
        end else if (inc && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_ZERO;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/strobe_align_check.sv
// Receive strobe cadence checker: finds, verifies and tracks the strobe position
// among marker words, flagging cadence errors once locked.
module strobe_align_check
    import strobe_chk_pkg::*;
#(
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] interval,
    input  logic             online,
    input  logic             rx_marker,
    input  logic             rx_strobe,
    input  logic             err_clr,
    output logic             aligned,
    output logic             strobe_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [RUN_W-1:0] LOCK_W   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] UNLOCK_W = RUN_W'(UNLOCK_CNT);

    chk_state_t       r_state;
    chk_state_t       w_state_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] w_pos_nxt;
    logic [RUN_W-1:0] r_good;
    logic [RUN_W-1:0] w_good_nxt;
    logic [RUN_W-1:0] r_bad;
    logic [RUN_W-1:0] w_bad_nxt;
    logic             r_aligned;
    logic             r_strobe_err;
    logic             w_err;
    logic             w_expected;
    logic [POS_W-1:0] w_pos_adv;
    logic [RUN_W-1:0] w_good_inc;
    logic [RUN_W-1:0] w_bad_inc;

    assign w_expected = (r_pos == interval);
    assign w_pos_adv  = w_expected ? 16'd0 : (r_pos + 16'd1);
    assign w_good_inc = run_inc(r_good);
    assign w_bad_inc  = run_inc(r_bad);

    // Next-state and counter updates; only marker cycles move the cadence.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_err       = 1'b0;
        if (!online) begin
            w_state_nxt = ST_IDLE;
            w_pos_nxt   = 16'd0;
            w_good_nxt  = 4'd0;
            w_bad_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (rx_marker && rx_strobe) begin
                        w_pos_nxt   = 16'd0;
                        w_good_nxt  = 4'd1;
                        w_bad_nxt   = 4'd0;
                        w_state_nxt = (LOCK_W == 4'd1) ? ST_LOCKED : ST_VERIFY;
                    end else if (rx_marker) begin
                        w_pos_nxt = w_pos_adv;
                    end else begin
                        w_pos_nxt = r_pos;
                    end
                end
                ST_VERIFY: begin
                    if (rx_marker && w_expected && rx_strobe) begin
                        w_pos_nxt  = 16'd0;
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == LOCK_W) begin
                            w_state_nxt = ST_LOCKED;
                            w_bad_nxt   = 4'd0;
                        end else begin
                            w_state_nxt = ST_VERIFY;
                        end
                    end else if (rx_marker && w_expected) begin
                        w_pos_nxt   = 16'd0;
                        w_state_nxt = ST_SEARCH;
                    end else if (rx_marker && rx_strobe) begin
                        // Strobe off-cadence: restart verification from this word.
                        w_pos_nxt  = 16'd0;
                        w_good_nxt = 4'd1;
                    end else if (rx_marker) begin
                        w_pos_nxt = w_pos_adv;
                    end else begin
                        w_pos_nxt = r_pos;
                    end
                end
                ST_LOCKED: begin
                    if (rx_marker) begin
                        w_pos_nxt = w_pos_adv;
                        if (w_expected && rx_strobe) begin
                            w_bad_nxt = 4'd0;
                        end else if (w_expected || rx_strobe) begin
                            w_err     = 1'b1;
                            w_bad_nxt = w_bad_inc;
                            if (w_bad_inc == UNLOCK_W) begin
                                w_state_nxt = ST_SEARCH;
                            end else begin
                                w_state_nxt = ST_LOCKED;
                            end
                        end else begin
                            w_bad_nxt = r_bad;
                        end
                    end else begin
                        w_pos_nxt = r_pos;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_pos_nxt   = 16'd0;
                    w_good_nxt  = 4'd0;
                    w_bad_nxt   = 4'd0;
                end
            endcase
        end
    end

    // State, cadence counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pos        <= 16'd0;
            r_good       <= 4'd0;
            r_bad        <= 4'd0;
            r_aligned    <= 1'b0;
            r_strobe_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_good       <= w_good_nxt;
            r_bad        <= w_bad_nxt;
            r_aligned    <= (w_state_nxt == ST_LOCKED);
            r_strobe_err <= w_err;
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err),
        .clr   (err_clr),
        .count (err_count)
    );

    assign aligned    = r_aligned;
    assign strobe_err = r_strobe_err;

endmodule

// File: doc/strobe_align_check.md
STROBE_ALIGN_CHECK -- requirements
Module: strobe_align_check

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: number of consecutive correctly placed strobes needed to declare alignment (range 1..15).
REQ-002 SHALL have parameter UNLOCK_CNT, default 3: number of consecutive misplaced or missing strobes needed to drop alignment (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port interval, input, 16 bits: marker words between strobes, same meaning as on the transmit strobe generator; 0 means a strobe on every marker word; quasi-static while online=1.
REQ-006 SHALL have port online, input, 1 bit: enables checking; 0 forces IDLE.
REQ-007 SHALL have port rx_marker, input, 1 bit: the current received word is a counted (marker) word.
REQ-008 SHALL have port rx_strobe, input, 1 bit: strobe bit of the current received word; ignored when rx_marker=0.
REQ-009 SHALL have port err_clr, input, 1 bit: synchronous clear of err_count.
REQ-010 SHALL have port aligned, output, 1 bit: strobe cadence is locked.
REQ-011 SHALL have port strobe_err, output, 1 bit: one-cycle pulse per cadence error while LOCKED.
REQ-012 SHALL have port err_count, output, 16 bits: saturating count of strobe_err pulses.

Function
REQ-013 SHALL act only on cycles with rx_marker=1 ("marker cycles"); other cycles leave all state unchanged except err_clr handling.
REQ-014 SHALL keep a 16-bit position counter pos; on a marker cycle, pos==interval marks the "expected" slot and pos then wraps to 0, otherwise pos increments by 1.
REQ-015 SHALL implement states IDLE, SEARCH, VERIFY, LOCKED, all registered.
REQ-016 IDLE: entered whenever online=0 (takes effect next cycle from any state); pos, good and bad counters are cleared; leaves to SEARCH on the first cycle with online=1.
REQ-017 SEARCH: a marker cycle with rx_strobe=1 seeds the cadence (pos:=0, good:=1) and moves to VERIFY, or directly to LOCKED if LOCK_CNT==1.
REQ-018 VERIFY: a strobe in the expected slot increments good; when good reaches LOCK_CNT the block moves to LOCKED.
REQ-019 VERIFY: a missing strobe in the expected slot moves the block to SEARCH.
REQ-020 VERIFY: a strobe in an unexpected slot re-seeds the cadence (pos:=0, good:=1) and the block stays in VERIFY.
REQ-021 LOCKED: a strobe in the expected slot clears bad.
REQ-022 LOCKED: a missing expected strobe or an unexpected strobe is one error; pos is not realigned; strobe_err pulses and bad increments.
REQ-023 LOCKED: when bad reaches UNLOCK_CNT the block moves to SEARCH.
REQ-024 aligned SHALL be registered and equal (state==LOCKED); it asserts in the cycle after the locking marker cycle and deasserts in the cycle after the unlocking error.
REQ-025 strobe_err SHALL be registered, assert in the cycle after the erroneous marker cycle, and never assert outside LOCKED.
REQ-026 err_count SHALL increment on each strobe_err event and saturate at 16'hFFFF.
REQ-027 err_clr SHALL zero err_count; err_clr coincident with an error event SHALL give err_count=1.
REQ-028 err_count SHALL be retained across online deassertion; only rst and err_clr clear it.
REQ-029 With interval=0, every marker word SHALL be an expected slot, so a missing strobe on any marker word is an error.
REQ-030 A change of interval while online=1 is unsupported; the only requirement is that no X propagates.

Reset
REQ-031 rst=1 SHALL asynchronously force state=IDLE, pos=0, good=0, bad=0, aligned=0, strobe_err=0, err_count=0.
REQ-032 Release of rst SHALL be glitch-free; the first active edge after release evaluates online normally.

Structure
REQ-033 The state enum and the LOCK_CNT/UNLOCK_CNT defaults SHALL live in shared package strobe_chk_pkg.
REQ-034 The error counter SHALL be a sub-module sat_counter (width parameter, inc, clr, count); everything else stays flat.
REQ-035 Target size is 120-400 lines of RTL with no memories.

Verification
REQ-036 interval=9, online=1, strobe on every 10th marker word, markers every cycle -> aligned=1 one cycle after the 4th strobe; strobe_err never asserts.
REQ-037 Locked at interval=9, drop 3 consecutive strobes -> 3 strobe_err pulses, err_count=3, aligned=0 after the 3rd; re-lock after 4 good strobes.
REQ-038 Locked, one extra strobe at pos=4, then good cadence -> 1 strobe_err, aligned stays 1, bad cleared at the next expected strobe.
REQ-039 interval=0, markers asserted on 50% of cycles, strobe on each marker word -> lock after 4 marker words; idle cycles cause no errors.
REQ-040 online dropped mid-VERIFY, and rst pulsed mid-LOCKED -> state=IDLE and aligned=0 the next cycle; err_count retained for the online drop and zeroed for rst.
REQ-041 err_count preloaded near 16'hFFFF by forced errors -> saturates at 16'hFFFF; err_clr coincident with an error gives err_count=1.
